// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte-in / serial-out handshake bundle for uart_tx_serializer
//   tx_data   - byte to transmit (master -> slave)
//   send      - one-cycle transmit request (master -> slave)
//   tx        - serial line, idle high (slave -> master)
//   tx_busy   - frame in flight (slave -> master)
//   data_sent - last accepted byte fully transmitted (slave -> master)
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       send;
  logic       tx;
  logic       tx_busy;
  logic       data_sent;
  modport master (output tx_data, send, input tx, tx_busy, data_sent);
  modport slave  (input tx_data, send, output tx, tx_busy, data_sent);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   bus          - uart_tx_serializer_if.slave: tx_data/send in, tx/tx_busy/data_sent out
// All outputs come straight from registers; next-state values are computed for
// the state being entered so tx changes on the same edge as the state.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_serializer_if.slave   bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          sent_q, sent_d;
  logic          last;
  assign last = cnt_q == LAST;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (bus.send) begin
          state_d = START;
          data_d  = bus.tx_data;
          sent_d  = 1'b0;
        end
      end
      START: state_d = last ? DATA : START;
      DATA: begin
        // bit index wraps 7 -> 0 as DATA is left, so it is clean for the next frame
        bit_d = last ? bit_q + 3'd1 : bit_q;
`ifdef UART_TX_PARITY_EN
        state_d = (last && bit_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: state_d = last ? STOP : PARITY;
`else
        state_d = (last && bit_q == 3'd7) ? STOP : DATA;
      end
`endif
      STOP: begin
        state_d = last ? IDLE : STOP;
        sent_d  = last ? 1'b1 : sent_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
    busy_d = state_d != IDLE;
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[bit_d] : state_d == PARITY ? ^data_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[bit_d] : 1'b1;
`endif
  end
  assign bus.tx        = tx_q;
  assign bus.tx_busy   = busy_q;
  assign bus.data_sent = sent_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed + random frames checked against a bit-list model of the UART frame
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FULL = NB * CPB;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  uart_tx_serializer_if bus();
  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // Frame bit i of byte b: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int n, input logic sent);
    repeat (n) begin
      @(negedge clk);
      chk("idle_tx", 8'(bus.tx), 8'd1);
      chk("idle_busy", 8'(bus.tx_busy), 8'd0);
      chk("idle_sent", 8'(bus.data_sent), 8'(sent));
    end
  endtask

  // Called at a negedge; sends b and checks upto cycles of the frame.
  // inj >= 0 pulses send with ib during the frame at that cycle.
  task automatic run_frame(input logic [7:0] b, input int inj, input logic [7:0] ib, input int upto);
    bus.tx_data = b;
    bus.send = 1'b1;
    @(posedge clk);
    #1 bus.send = 1'b0;
    bus.tx_data = 8'($urandom);
    for (int k = 0; k < upto; k++) begin
      @(negedge clk);
      chk($sformatf("tx[%0h]c%0d", b, k), 8'(bus.tx), 8'(frame_bit(b, k / CPB)));
      chk("busy", 8'(bus.tx_busy), 8'd1);
      chk("sent_low", 8'(bus.data_sent), 8'd0);
      bus.send = (k == inj);
      if (k == inj) bus.tx_data = ib;
    end
    if (upto == FULL) begin
      @(negedge clk);
      chk("end_busy", 8'(bus.tx_busy), 8'd0);
      chk("end_sent", 8'(bus.data_sent), 8'd1);
      chk("end_tx", 8'(bus.tx), 8'd1);
    end
  endtask

  initial begin
    bus.send = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", 8'(bus.tx), 8'd1);
    chk("rst_busy", 8'(bus.tx_busy), 8'd0);
    chk("rst_sent", 8'(bus.data_sent), 8'd0);
    reset = 1'b1;
    run_frame(8'hAB, -1, 8'h00, FULL);
    idle_chk(3, 1'b1);
    run_frame(8'h03, 10, 8'hFF, FULL);
    idle_chk(8, 1'b1);
    run_frame(8'hAB, -1, 8'h00, FULL);
    run_frame(8'h02, -1, 8'h00, FULL);
    idle_chk(2, 1'b1);
    run_frame(8'h55, -1, 8'h00, 17);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", 8'(bus.tx), 8'd1);
    chk("abort_busy", 8'(bus.tx_busy), 8'd0);
    chk("abort_sent", 8'(bus.data_sent), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_chk(2, 1'b0);
    run_frame(8'h01, -1, 8'h00, FULL);
    run_frame(8'h07, -1, 8'h00, FULL);
    run_frame(8'h03, -1, 8'h00, FULL);
    repeat (8) begin
      run_frame(8'($urandom), -1, 8'h00, FULL);
      idle_chk(int'($urandom_range(0, 3)), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
